// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Multiplies by shift-add and divides by restoring division, one bit per
// cycle. Signed operations run on magnitudes, and the signs are applied
// when the result is written to HI/LO.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       MDop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    // Two's-complement negate when n is set (WIDTH bits)
    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Two's-complement negate when n is set (2*WIDTH bits)
    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div_q, div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d, dz_q, dz_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic                 sgn, is_div, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0]   acc_step, prod;
    logic [WIDTH-1:0]     res_hi, res_lo;

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Operand conditioning at issue: signed views, sign flags, magnitudes
    always_comb begin
        a_s    = A;
        b_s    = B;
        sgn    = MDop[0];
        is_div = MDop[1];
        a_neg  = sgn & a_s[WIDTH-1];
        b_neg  = sgn & b_s[WIDTH-1];
        a_mag  = cneg_w(A, a_neg);
        b_mag  = cneg_w(B, b_neg);
    end

    // One radix-2 step plus sign-corrected final result from that step.
    // acc holds {upper, lower} product for multiply, {remainder, quotient/dividend} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial = div_shift - {1'b0, opnd_q};
        if (div_q) begin
            if (!div_trial[WIDTH]) acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                   acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
        prod = cneg_2w(acc_step, neg_p_q);
        if (div_q) begin
            // With a zero divisor every trial succeeds and the dividend magnitude
            // shifts fully into the remainder, so only the quotient needs forcing.
            res_lo = dz_q ? '1 : cneg_w(acc_step[WIDTH-1:0], neg_p_q);
            res_hi = cneg_w(acc_step[2*WIDTH-1:WIDTH], neg_r_q);
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    // Next-state: issue decode in IDLE, iteration and result write in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div_d   = div_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        dz_d    = dz_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (MDop)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            state_d = RUN;
                            cnt_d   = '0;
                            div_d   = is_div;
                            neg_p_d = a_neg ^ b_neg;
                            neg_r_d = a_neg;
                            dz_d    = is_div & (B == '0);
                            opnd_d  = is_div ? b_mag : a_mag;
                            acc_d   = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                        end
                        3'b100:  hi_d = A;
                        3'b101:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and architectural registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Datapath working registers, always reloaded at issue so no reset needed
    always_ff @(posedge clk) begin
        div_q   <= div_d;
        neg_p_q <= neg_p_d;
        neg_r_q <= neg_r_d;
        dz_q    <= dz_d;
        opnd_q  <= opnd_d;
        acc_q   <= acc_d;
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed testbench for mdu_iter: a 32-bit and an 8-bit instance on one clock.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start8;
    logic [2:0]  op32, op8;
    logic [31:0] a32, b32, hi32, lo32;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy32, done32, busy8, done8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .MDop(op32), .A(a32), .B(b32),
        .busy(busy32), .done(done32), .HI(hi32), .LO(lo32)
    );

    mdu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .MDop(op8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .HI(hi8), .LO(lo8)
    );

    // Issue a 32-bit op (caller sits at a negedge); returns in the done cycle.
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic busy_ok, output logic hold_ok, output logic done_ok,
                         output logic [31:0] hi, output logic [31:0] lo);
        logic [31:0] h0, l0;
        h0 = hi32; l0 = lo32;
        op32 = op; a32 = a; b32 = b; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; a32 = ~a; b32 = ~b;
        busy_ok = 1'b1; hold_ok = 1'b1; done_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (busy32 !== 1'b1) busy_ok = 1'b0;
            if (done32 !== 1'b0) done_ok = 1'b0;
            if (hi32 !== h0 || lo32 !== l0) hold_ok = 1'b0;
            @(negedge clk);
        end
        if (done32 !== 1'b1 || busy32 !== 1'b0) done_ok = 1'b0;
        hi = hi32; lo = lo32;
    endtask

    // Same for the 8-bit instance.
    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic busy_ok, output logic done_ok,
                        output logic [7:0] hi, output logic [7:0] lo);
        op8 = op; a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b;
        busy_ok = 1'b1; done_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (busy8 !== 1'b1) busy_ok = 1'b0;
            if (done8 !== 1'b0) done_ok = 1'b0;
            @(negedge clk);
        end
        if (done8 !== 1'b1 || busy8 !== 1'b0) done_ok = 1'b0;
        hi = hi8; lo = lo8;
    endtask

    task automatic test_reset();
        logic bo, ho, dn, seen;
        logic [31:0] h, l;
        rst = 1'b1; start32 = 1'b0; start8 = 1'b0;
        op32 = 3'b000; op8 = 3'b000; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (hi32 !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi32); end
        n_checks++; if (lo32 !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo32); end
        n_checks++; if (busy32 !== 1'b0 || done32 !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: busy %b done %b want 0 0", busy32, done32); end
        n_checks++; if (hi8 !== 8'h0 || lo8 !== 8'h0) begin n_fail++; $display("FAIL reset_w8: got %h/%h want 00/00", hi8, lo8); end
        // load HI/LO so a reset-induced clear is visible
        op32 = 3'b100; a32 = 32'h55; start32 = 1'b1;
        @(negedge clk);
        op32 = 3'b101; a32 = 32'hAA;
        @(negedge clk);
        start32 = 1'b0;
        op32 = 3'b000; a32 = 32'd5; b32 = 32'd3; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (hi32 !== 32'h0 || lo32 !== 32'h0) begin n_fail++; $display("FAIL midrun_rst_hilo: got %h/%h want 0/0", hi32, lo32); end
        n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_busy: got %b want 0", busy32); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done32 !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_done: got pulse %b want 0", seen); end
        // rst and start on the same edge: start is dropped
        op32 = 3'b000; a32 = 32'd5; b32 = 32'd3; start32 = 1'b1; rst = 1'b1;
        @(negedge clk);
        start32 = 1'b0; rst = 1'b0;
        n_checks++; if (busy32 !== 1'b0) begin n_fail++; $display("FAIL rst_prio_busy: got %b want 0", busy32); end
        // next start after reset is accepted normally
        run32(3'b010, 32'd100, 32'd7, bo, ho, dn, h, l);
        n_checks++; if (bo !== 1'b1 || dn !== 1'b1) begin n_fail++; $display("FAIL post_rst_divu_timing: busy_ok %b done_ok %b want 1 1", bo, dn); end
        n_checks++; if (l !== 32'd14 || h !== 32'd2) begin n_fail++; $display("FAIL post_rst_divu: got hi %h lo %h want 2 0e", h, l); end
    endtask

    task automatic test_multu();
        logic bo, ho, dn;
        logic [31:0] h, l;
        @(negedge clk);
        run32(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, bo, ho, dn, h, l);
        n_checks++; if (bo !== 1'b1) begin n_fail++; $display("FAIL multu_busy: busy_ok %b want 1", bo); end
        n_checks++; if (ho !== 1'b1) begin n_fail++; $display("FAIL multu_hold: hold_ok %b want 1", ho); end
        n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL multu_done: done_ok %b want 1", dn); end
        n_checks++; if (h !== 32'hFFFFFFFE || l !== 32'h00000001) begin n_fail++; $display("FAIL multu: got %h_%h want fffffffe_00000001", h, l); end
        @(negedge clk);
        n_checks++; if (done32 !== 1'b0) begin n_fail++; $display("FAIL multu_done_width: got %b want 0", done32); end
    endtask

    task automatic test_mult();
        logic bo, ho, dn;
        logic [31:0] h, l;
        @(negedge clk);
        run32(3'b001, 32'hFFFFFFFD, 32'd7, bo, ho, dn, h, l);
        n_checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_neg3x7: got %h_%h want ffffffff_ffffffeb", h, l); end
    endtask

    task automatic test_div();
        logic bo, ho, dn;
        logic [31:0] h, l;
        @(negedge clk);
        run32(3'b011, 32'hFFFFFFF9, 32'd2, bo, ho, dn, h, l);
        n_checks++; if (l !== 32'hFFFFFFFD || h !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg7by2: got hi %h lo %h want ffffffff fffffffd", h, l); end
        @(negedge clk);
        run32(3'b010, 32'd100, 32'd7, bo, ho, dn, h, l);
        n_checks++; if (l !== 32'd14 || h !== 32'd2) begin n_fail++; $display("FAIL divu_100by7: got hi %h lo %h want 2 0e", h, l); end
    endtask

    task automatic test_corner_div();
        logic bo, ho, dn;
        logic [31:0] h, l;
        @(negedge clk);
        run32(3'b010, 32'h12345678, 32'h0, bo, ho, dn, h, l);
        n_checks++; if (dn !== 1'b1) begin n_fail++; $display("FAIL divu_by0_latency: done_ok %b want 1", dn); end
        n_checks++; if (l !== 32'hFFFFFFFF || h !== 32'h12345678) begin n_fail++; $display("FAIL divu_by0: got hi %h lo %h want 12345678 ffffffff", h, l); end
        @(negedge clk);
        run32(3'b011, 32'hFFFFFFF9, 32'h0, bo, ho, dn, h, l);
        n_checks++; if (l !== 32'hFFFFFFFF || h !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL div_by0_neg: got hi %h lo %h want fffffff9 ffffffff", h, l); end
        @(negedge clk);
        run32(3'b011, 32'h80000000, 32'hFFFFFFFF, bo, ho, dn, h, l);
        n_checks++; if (l !== 32'h80000000 || h !== 32'h0) begin n_fail++; $display("FAIL div_overflow: got hi %h lo %h want 0 80000000", h, l); end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        op32 = 3'b100; a32 = 32'hDEAD; start32 = 1'b1;
        @(negedge clk);
        n_checks++; if (hi32 !== 32'hDEAD || busy32 !== 1'b0 || done32 !== 1'b0) begin n_fail++; $display("FAIL mthi: hi %h busy %b done %b want dead 0 0", hi32, busy32, done32); end
        op32 = 3'b101; a32 = 32'hBEEF;
        @(negedge clk);
        start32 = 1'b0;
        n_checks++; if (lo32 !== 32'hBEEF || hi32 !== 32'hDEAD || busy32 !== 1'b0 || done32 !== 1'b0) begin n_fail++; $display("FAIL mtlo: hi %h lo %h busy %b done %b want dead beef 0 0", hi32, lo32, busy32, done32); end
    endtask

    task automatic test_issue_while_busy();
        @(negedge clk);
        op32 = 3'b000; a32 = 32'd6; b32 = 32'd7; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (3) @(negedge clk);
        op32 = 3'b100; a32 = 32'h1111; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        n_checks++; if (hi32 !== 32'hDEAD) begin n_fail++; $display("FAIL mthi_busy: hi %h want dead", hi32); end
        op32 = 3'b010; a32 = 32'd99; b32 = 32'd4; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (26) @(negedge clk);
        n_checks++; if (done32 !== 1'b0 || busy32 !== 1'b1) begin n_fail++; $display("FAIL busy_restart_early: done %b busy %b want 0 1", done32, busy32); end
        @(negedge clk);
        n_checks++; if (done32 !== 1'b1 || hi32 !== 32'h0 || lo32 !== 32'd42) begin n_fail++; $display("FAIL start_midrun: done %b hi %h lo %h want 1 0 2a", done32, hi32, lo32); end
    endtask

    task automatic test_reserved();
        @(negedge clk);
        op32 = 3'b110; a32 = 32'h7777; b32 = 32'h3; start32 = 1'b1;
        @(negedge clk);
        op32 = 3'b111;
        @(negedge clk);
        start32 = 1'b0;
        n_checks++; if (hi32 !== 32'h0 || lo32 !== 32'd42 || busy32 !== 1'b0) begin n_fail++; $display("FAIL reserved_op: hi %h lo %h busy %b want 0 2a 0", hi32, lo32, busy32); end
    endtask

    task automatic test_back_to_back();
        logic bo, dn;
        logic [7:0] h, l;
        @(negedge clk);
        run8(3'b001, 8'h80, 8'h80, bo, dn, h, l);
        n_checks++; if (bo !== 1'b1 || dn !== 1'b1) begin n_fail++; $display("FAIL w8_mult_timing: busy_ok %b done_ok %b want 1 1", bo, dn); end
        n_checks++; if (h !== 8'h40 || l !== 8'h00) begin n_fail++; $display("FAIL w8_mult: got %h_%h want 40_00", h, l); end
        // issued in the done cycle
        run8(3'b010, 8'd200, 8'd7, bo, dn, h, l);
        n_checks++; if (bo !== 1'b1 || dn !== 1'b1) begin n_fail++; $display("FAIL w8_b2b_accept: busy_ok %b done_ok %b want 1 1", bo, dn); end
        n_checks++; if (l !== 8'h1C || h !== 8'h04) begin n_fail++; $display("FAIL w8_b2b_divu: got hi %h lo %h want 04 1c", h, l); end
        @(negedge clk);
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL w8_done_width: got %b want 0", done8); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_corner_div();
        test_mthi_mtlo();
        test_issue_while_busy();
        test_reserved();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit with HI/LO result registers for the multi-cycle MIPS CPU. It adds mult/multu/div/divu/mthi/mtlo support next to the existing ALU. It sits beside the ALU, taking operands from the A/B operand delay registers, and exposes busy so the controller can stall instruction issue. All arithmetic is radix-2 iterative, one bit per cycle, with data width as a parameter.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and even.
- clk  in  1  system clock, rising-edge active.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  issue request; sampled every rising edge.
- MDop  in  3  000 multu, 001 mult, 010 divu, 011 div, 100 mthi, 101 mtlo; 110/111 reserved, treated as no-op.
- A  in  WIDTH  operand A: multiplicand, dividend, or mthi/mtlo source.
- B  in  WIDTH  operand B: multiplier or divisor.
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse when HI/LO receive a mult/div result.
- HI  out  WIDTH  HI register: product upper half or remainder.
- LO  out  WIDTH  LO register: product lower half or quotient.

## Operation
- **States**
  - IDLE: busy=0.
  - RUN: busy=1. Iteration counter of $clog2(WIDTH)+1 bits counts WIDTH iterations.
  - Transitions: IDLE→RUN on start with mult/div MDop. RUN→IDLE when the last iteration completes.
- **Operand capture**: A, B, and the signed flag (MDop[0]) are captured on the start edge. The inputs may change freely afterwards.
- **Signed ops**: operate on magnitudes |A| and |B|. Apply signs at the final write.
  - Product is negated if the signs differ.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- **Multiply**: shift-add. The 2·WIDTH-bit product splits as HI = upper WIDTH bits, LO = lower WIDTH bits.
- **Divide**: restoring divide. LO = quotient, HI = remainder.
- **Divide by zero** (B==0, div or divu): LO = all ones, HI = A unmodified. Still takes the full latency.
- **Signed overflow** (div, A = most-negative, B = −1): LO = most-negative, HI = 0.
- **mthi / mtlo**: single-cycle. HI (or LO) ← A on the start edge. busy and done stay 0.
- **start while busy**: ignored for every MDop, including mthi/mtlo. The running operation is unaffected. The controller must not issue while busy.
- **HI/LO during RUN**: hold their previous values. Intermediate products and partial remainders live in internal registers only.
- **Reserved MDop with start**: no state change.

## Timing
- **Reset values**: HI=0, LO=0, busy=0, done=0, state IDLE.
- **Mult/div sequence**, with the start edge called E0:
  - busy=1 after E0 through edge E_WIDTH.
  - At E_WIDTH, HI/LO are written, busy falls, and done=1 for exactly one cycle.
  - Result visible WIDTH cycles after E0 (32 for the default WIDTH).
- **Back-to-back issue**: a new start may be accepted at E_WIDTH+1, i.e. in the cycle done is high. Sustained throughput is one op per WIDTH+1 cycles.
- **mthi/mtlo**: new value visible the cycle after the start edge.
- **Reset mid-operation**: rst asserted during RUN aborts the operation at that edge.
  - Counter is cleared; HI/LO go to 0.
  - No done pulse is generated.
- **Reset priority**: rst on the same edge as start takes priority, and start is dropped.
- **Output drive**: all outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset**: hold rst 2 cycles mid-RUN of a multu → HI=LO=0, busy=0, no done pulse, next start accepted normally.
- **multu**: A=0xFFFFFFFF, B=0xFFFFFFFF → after 32 cycles HI=0xFFFFFFFE, LO=0x00000001, done pulse 1 cycle. mult: A=−3, B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **div**: A=−7, B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu: A=100, B=7 → LO=14, HI=2.
- **Corner divides**:
  - divu with B=0, A=0x12345678 → LO=0xFFFFFFFF, HI=0x12345678.
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- **Issue rules**:
  - mthi A=0xDEAD then mtlo A=0xBEEF on consecutive cycles → HI/LO update next cycle each, busy never asserts.
  - mthi issued while busy → HI unchanged.
  - start pulsed mid-RUN → ignored, original result correct.
- **WIDTH=8 instance**: mult A=0x80, B=0x80 → HI=0x40, LO=0x00 after 8 cycles. Back-to-back start issued in the done cycle is accepted.
